// File: rtl/cz_intersect_engine.sv
// rtl/cz_intersect_engine.sv - sequential constrained-zonotope generalized-intersection row engine
//
// Computes the new constraint rows of Z intersect_R Y one element at a time
// through a single MAC:
//   OUT.A[znc+ync+i][j]       = sum_k R[i][k] * Z.G[k][j]     (GEN)
//   OUT.A[znc+ync+i][zng+j]   = -Y.G[i][j]                    (NEG)
//   OUT.b[znc+ync+i]          = Y.c[i] - sum_k R[i][k] * Z.c[k] (CONST)
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      launch (sampled in IDLE only)
//   n_i .. yn_i                  operand dimensions, latched at start
//   busy_o, done_o, err_o        status; err_o is valid with done_o
//   out_ng_o, out_nc_o           generator / constraint counts of OUT
//   ra_*                         R read port (data one cycle after request)
//   rb_*                         operand read port: sel 0=Z.G 1=Z.c 2=Y.G 3=Y.c
//   wr_*                         OUT write port: sel 0=OUT.A 1=OUT.b
//
// Build option: CZ_INTERSECT_SAT_EN selects saturating arithmetic; when it is
// not defined every operation wraps modulo 2^DATA_WIDTH.

module cz_intersect_engine #(
    parameter int NMAX       = 512,
    parameter int NGMAX      = 512,
    parameter int NCMAX      = 512,
    parameter int NRMAX      = 512,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [$clog2(NMAX):0]      n_i,
    input  logic [$clog2(NGMAX):0]     zng_i,
    input  logic [$clog2(NGMAX):0]     yng_i,
    input  logic [$clog2(NCMAX):0]     znc_i,
    input  logic [$clog2(NCMAX):0]     ync_i,
    input  logic [$clog2(NRMAX):0]     nr_i,
    input  logic [$clog2(NMAX):0]      yn_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [$clog2(NGMAX)+1:0]   out_ng_o,
    output logic [$clog2(NCMAX)+1:0]   out_nc_o,
    output logic                       ra_en_o,
    output logic [$clog2(NRMAX)-1:0]   ra_row_o,
    output logic [$clog2(NMAX)-1:0]    ra_col_o,
    input  logic [DATA_WIDTH-1:0]      ra_data_i,
    output logic                       rb_en_o,
    output logic [1:0]                 rb_sel_o,
    output logic [$clog2(NMAX)-1:0]    rb_row_o,
    output logic [$clog2(NGMAX)-1:0]   rb_col_o,
    input  logic [DATA_WIDTH-1:0]      rb_data_i,
    output logic                       wr_en_o,
    output logic                       wr_sel_o,
    output logic [$clog2(NCMAX)+1:0]   wr_row_o,
    output logic [$clog2(NGMAX):0]     wr_col_o,
    output logic [DATA_WIDTH-1:0]      wr_data_o
);

    localparam int W   = DATA_WIDTH;
    localparam int AN  = $clog2(NMAX);
    localparam int AG  = $clog2(NGMAX);
    localparam int AR  = $clog2(NRMAX);
    localparam int NW  = AN + 1;
    localparam int GW  = AG + 1;
    localparam int CW  = $clog2(NCMAX) + 1;
    localparam int RW  = AR + 1;
    localparam int OCW = CW + 1;
    localparam int OGW = GW + 1;

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] SEL_ZG = 2'd0;
    localparam logic [1:0] SEL_ZC = 2'd1;
    localparam logic [1:0] SEL_YG = 2'd2;
    localparam logic [1:0] SEL_YC = 2'd3;

    typedef enum logic [2:0] {IDLE, GEN, NEG, CONST, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q;
    logic [GW-1:0]   zng_q, yng_q;
    logic [RW-1:0]   nr_q;
    logic [OCW-1:0]  row_base_q;
    logic [OGW-1:0]  out_ng_q;
    logic [OCW-1:0]  out_nc_q;
    logic [RW-1:0]   i_q;
    logic [GW-1:0]   j_q;
    logic [NW-1:0]   ph_q;
    logic [W-1:0]    acc_q;

    logic            dims_bad;
    logic            elem_end;
    logic            j_last;
    logic            row_last;
    logic [OCW-1:0]  wr_row;
    logic [W-1:0]    prod_w;

    // Add or subtract (a - b when sub) at element width, saturating or wrapping.
    function automatic logic [W-1:0] addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
`ifdef CZ_INTERSECT_SAT_EN
        logic [W:0] s;
        s = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        if (s[W] != s[W-1]) return s[W] ? MIN_V : MAX_V;
        return s[W-1:0];
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

    // Q-format product: full-width multiply, arithmetic shift, then narrow.
    logic signed [2*W-1:0] prod_full;
    logic signed [2*W-1:0] prod_sh;
    assign prod_full = $signed(ra_data_i) * $signed(rb_data_i);
    assign prod_sh   = prod_full >>> FRAC_BITS;

`ifdef CZ_INTERSECT_SAT_EN
    localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    always_comb begin
        if (prod_sh > PMAX)      prod_w = MAX_V;
        else if (prod_sh < PMIN) prod_w = MIN_V;
        else                     prod_w = prod_sh[W-1:0];
    end
`else
    logic unused_prod_hi;
    assign prod_w         = prod_sh[W-1:0];
    assign unused_prod_hi = ^prod_sh[2*W-1:W];
`endif

    assign dims_bad = (32'(yn_i) != 32'(nr_i)) || (nr_i == '0) || (n_i == '0)
                   || (32'(n_i) > NMAX)    || (32'(yn_i) > NMAX)
                   || (32'(zng_i) > NGMAX) || (32'(yng_i) > NGMAX)
                   || (32'(znc_i) > NCMAX) || (32'(ync_i) > NCMAX)
                   || (32'(nr_i) > NRMAX);

    assign wr_row = row_base_q + OCW'(i_q);

    // Element boundary and loop-exit flags for the current state.
    always_comb begin
        elem_end = 1'b0;
        j_last   = 1'b0;
        row_last = (32'(i_q) + 1) >= 32'(nr_q);
        case (state_q)
            GEN: begin
                elem_end = (ph_q == n_q + NW'(1));
                j_last   = (j_q + GW'(1) == zng_q);
            end
            CONST: elem_end = (ph_q == n_q + NW'(1));
            NEG: begin
                elem_end = (ph_q == NW'(1));
                j_last   = (j_q + GW'(1) == yng_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (dims_bad)            state_d = ERR;
                    else if (zng_i != '0)    state_d = GEN;
                    else if (yng_i != '0)    state_d = NEG;
                    else                     state_d = CONST;
                end
            end
            GEN:   if (elem_end && j_last) state_d = (yng_q != '0) ? NEG : CONST;
            NEG:   if (elem_end && j_last) state_d = CONST;
            CONST: begin
                if (elem_end) begin
                    if (row_last)            state_d = DONE;
                    else if (zng_q != '0)    state_d = GEN;
                    else if (yng_q != '0)    state_d = NEG;
                    else                     state_d = CONST;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q        <= '0;
            zng_q      <= '0;
            yng_q      <= '0;
            nr_q       <= '0;
            row_base_q <= '0;
            out_ng_q   <= '0;
            out_nc_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            ph_q       <= '0;
            acc_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !dims_bad) begin
                        n_q        <= n_i;
                        zng_q      <= zng_i;
                        yng_q      <= yng_i;
                        nr_q       <= nr_i;
                        row_base_q <= OCW'(znc_i) + OCW'(ync_i);
                        out_ng_q   <= OGW'(zng_i) + OGW'(yng_i);
                        out_nc_q   <= OCW'(znc_i) + OCW'(ync_i) + OCW'(nr_i);
                        i_q        <= '0;
                        j_q        <= '0;
                        ph_q       <= '0;
                    end
                end
                GEN, NEG, CONST: begin
                    if (elem_end) begin
                        ph_q <= '0;
                        // Column index restarts whenever the loop kind changes.
                        if (state_d != state_q || state_q == CONST) j_q <= '0;
                        else                                         j_q <= j_q + GW'(1);
                        if (state_q == CONST) i_q <= i_q + RW'(1);
                    end else begin
                        ph_q <= ph_q + NW'(1);
                    end
                    // Dot product: clear in d0, accumulate returning data in d1..dn.
                    if (state_q != NEG) begin
                        if (ph_q == '0)        acc_q <= '0;
                        else if (ph_q <= n_q)  acc_q <= addsub(acc_q, prod_w, 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        out_ng_o  = '0;
        out_nc_o  = '0;
        ra_en_o   = 1'b0;
        ra_row_o  = '0;
        ra_col_o  = '0;
        rb_en_o   = 1'b0;
        rb_sel_o  = SEL_ZG;
        rb_row_o  = '0;
        rb_col_o  = '0;
        wr_en_o   = 1'b0;
        wr_sel_o  = 1'b0;
        wr_row_o  = '0;
        wr_col_o  = '0;
        wr_data_o = '0;
        case (state_q)
            GEN, CONST: begin
                busy_o = 1'b1;
                if (ph_q < n_q) begin
                    ra_en_o  = 1'b1;
                    ra_row_o = AR'(i_q);
                    ra_col_o = AN'(ph_q);
                    rb_en_o  = 1'b1;
                    rb_sel_o = (state_q == GEN) ? SEL_ZG : SEL_ZC;
                    rb_row_o = AN'(ph_q);
                    rb_col_o = (state_q == GEN) ? AG'(j_q) : '0;
                end else if (state_q == CONST && ph_q == n_q) begin
                    // Y.c[i] arrives in the write cycle, alongside the finished acc.
                    rb_en_o  = 1'b1;
                    rb_sel_o = SEL_YC;
                    rb_row_o = AN'(i_q);
                end
                if (elem_end) begin
                    wr_en_o  = 1'b1;
                    wr_row_o = wr_row;
                    if (state_q == GEN) begin
                        wr_col_o  = j_q;
                        wr_data_o = acc_q;
                    end else begin
                        wr_sel_o  = 1'b1;
                        wr_data_o = addsub(rb_data_i, acc_q, 1'b1);
                    end
                end
            end
            NEG: begin
                busy_o = 1'b1;
                if (ph_q == '0) begin
                    rb_en_o  = 1'b1;
                    rb_sel_o = SEL_YG;
                    rb_row_o = AN'(i_q);
                    rb_col_o = AG'(j_q);
                end else begin
                    wr_en_o   = 1'b1;
                    wr_row_o  = wr_row;
                    wr_col_o  = zng_q + j_q;
                    wr_data_o = addsub('0, rb_data_i, 1'b1);
                end
            end
            DONE: done_o = 1'b1;
            ERR: begin
                done_o = 1'b1;
                err_o  = 1'b1;
            end
            default: ;
        endcase
        if (busy_o || state_q == DONE) begin
            out_ng_o = out_ng_q;
            out_nc_o = out_nc_q;
        end
    end

endmodule

// File: doc/cz_intersect_engine.md
# cz_intersect_engine

Sequential generalized-intersection engine for constrained zonotopes. It computes Z ∩_R Y = ⟨Z.c, [Z.G 0], [Z.A 0; 0 Y.A; R·Z.G −Y.G], [Z.b; Y.b; Y.c − R·Z.c]⟩. It streams operands from external matrix memories through one MAC and writes only the new constraint rows of OUT.A and OUT.b. The block sits beside the existing CZonotope copy logic, which still places the Z.A, Y.A, Z.b and Y.b blocks. It replaces the combinational constraint-row datapath and adds a start/done handshake, dimension checking and runtime-sized loops.

## Interface

Parameters:
- NMAX, 512, max state dimension n
- NGMAX, 512, max generators per operand
- NCMAX, 512, max constraints per operand
- NRMAX, 512, max rows of R
- DATA_WIDTH, 32, signed two's-complement element width
- FRAC_BITS, 16, fractional bits (Q format)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  launch; sampled in IDLE only
- n_i, zng_i, yng_i, znc_i, ync_i, nr_i, yn_i  in  clog2(max)+1 each  dimensions; latched at start
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  dimension error; valid with done_o
- out_ng_o, out_nc_o  out  clog2(NGMAX)+2, clog2(NCMAX)+2  zng+yng and znc+ync+nr; latched at start
- ra_en_o, ra_row_o, ra_col_o  out  1/clog2(NRMAX)/clog2(NMAX)  R read request
- ra_data_i  in  DATA_WIDTH  R data, 1 cycle after request
- rb_en_o  out  1  operand read request
- rb_sel_o  out  2  0 = Z.G, 1 = Z.c, 2 = Y.G, 3 = Y.c
- rb_row_o, rb_col_o  out  clog2(NMAX)/clog2(NGMAX)  operand read address
- rb_data_i  in  DATA_WIDTH  operand data, 1 cycle after request
- wr_en_o  out  1  OUT write strobe
- wr_sel_o  out  1  0 = OUT.A, 1 = OUT.b
- wr_row_o, wr_col_o  out  clog2(NCMAX)+2, clog2(NGMAX)+1  OUT address
- wr_data_o  out  DATA_WIDTH  write data

## Operation

- States: IDLE, GEN, NEG, CONST, DONE, ERR.
- Reset state: IDLE. All outputs are 0 in reset and while idle.
- start_i in IDLE with a bad dimension set goes to ERR. Bad means yn_i≠nr_i, nr_i=0, n_i=0, or any dimension above its max.
- start_i with good dimensions goes to GEN with row i=0, or to NEG if zng=0.
- start_i while busy is ignored.
- GEN, for each column j<zng: acc = Σk R[i][k]·Z.G[k][j]; write OUT.A[znc+ync+i][j] = acc.
- NEG, for each j<yng: write OUT.A[znc+ync+i][zng+j] = −Y.G[i][j]. NEG is skipped when yng=0.
- CONST: acc = Σk R[i][k]·Z.c[k]; write OUT.b[znc+ync+i] = Y.c[i] − acc.
- After CONST: i+1<nr returns to GEN (or NEG); otherwise go to DONE.
- DONE and ERR last one cycle each, then return to IDLE.
- Arithmetic: product is the full 2·DATA_WIDTH result, arithmetic-shifted right by FRAC_BITS, truncated to DATA_WIDTH. Accumulate, negate and subtract are DATA_WIDTH wide; overflow per Configuration.
- The accumulator clears at the start of every dot product.

## Timing

- Cycle S is the cycle in which start_i is sampled high in IDLE.
- busy_o is high from S+1 through the final write cycle.
- done_o pulses in the cycle after the final write.
- ERR path: done_o=1 and err_o=1 in S+1; busy_o stays low; no reads or writes occur.
- Dot-product element (GEN, CONST), period n+2:
  - d0..d(n−1): ra and rb requests for k=0..n−1.
  - acc updates at the end of d1..dn.
  - CONST issues the Y.c[i] read on port B in cycle dn.
  - d(n+1): wr_en_o=1.
- NEG element, period 2: read issued in e0; write in e1 with wr_data_o = −rb_data_i.
- Total busy cycles: nr·((zng+1)·(n+2) + 2·yng).
- rst_i mid-operation: returns to IDLE the next cycle. All outputs drop, no done_o pulse, partial writes are not undone.

## Configuration

- CZ_INTERSECT_SAT_EN defined:
  - product, accumulate, subtract and negate saturate to [−2^(W−1), 2^(W−1)−1].
  - −(−2^(W−1)) gives 2^(W−1)−1.
- Undefined: all of the above wrap modulo 2^W, and −min = min.

## Test plan

- Nominal (FRAC_BITS=0): n=2, nr=yn=1, zng=2, yng=1, znc=1, ync=0. R=[1 2], Z.G=[[3,4],[5,6]], Z.c=[1,1], Y.G=[[7]], Y.c=[10].
  -> A[1][0]=13, A[1][1]=16, A[1][2]=−7, b[1]=7.
  -> busy 14 cycles, done in S+15.
- Dimension error: yn=2, nr=1 -> done=err=1 in S+1, no wr_en_o.
- yng=0, zng=0, n=1, nr=1: R=[2], Z.c=[3], Y.c=[1].
  -> single write b[znc+ync]=−5; 3 busy cycles.
- Overflow (W=8, FRAC_BITS=0): R=[100], Z.G=[[2]].
  -> A value 127 with SAT_EN; −56 without.
- rst_i asserted in cycle S+4 of the nominal case -> IDLE in S+5, no further writes, no done; a new start then completes normally.
- start_i held high through a whole run -> exactly one operation per IDLE sampling; re-launch only after done.
